weight_chain_sequencer: RTL and testbench
=========================================

WEIGHT_CHAIN_SEQUENCER -- requirements
Module: weight_chain_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one input vector element.
REQ-002 SHALL have parameter RESULT_WIDTH, default 16, result width; the chain result bus is RESULT_WIDTH+1 bits, with the MSB as the valid flag.
REQ-003 SHALL have parameter INDEX_WIDTH, default 10, width of the chain index bus.
REQ-004 SHALL have parameter WEIGHT_AMOUNT, default 4, elements per vector (at least 2).
REQ-005 SHALL have parameter NUM_CELLS, default 4, number of cells in the attached chain, which is also the number of results per vector.
REQ-006 SHALL have parameter FIFO_DEPTH, default 8, result FIFO entries (a power of 2, at least NUM_CELLS).
REQ-007 SHALL have ports: clk  in  1  the single clock, rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 in_value  in  DATA_WIDTH  vector element; in_valid  in  1; in_ready  out  1.
REQ-010 chain_value  out  DATA_WIDTH; chain_index  out  INDEX_WIDTH; chain_enable  out  1; chain_result  out  RESULT_WIDTH+1  (these drive the first cell of the chain).
REQ-011 chain_out_result  in  RESULT_WIDTH+1  the last cell's result output.
REQ-012 res_data  out  RESULT_WIDTH; res_valid  out  1; res_ready  in  1.
REQ-013 busy  out  1, meaning the state is not IDLE or results are outstanding; overflow  out  1, a sticky error flag.

Function
REQ-014 SHALL implement states FLUSH, IDLE and STREAM.
REQ-015 FLUSH SHALL hold in_ready=0, discard all flagged chain_out_result words, and last exactly 2*NUM_CELLS+WEIGHT_AMOUNT cycles before moving to IDLE.
REQ-016 In IDLE, in_ready SHALL equal (credits >= NUM_CELLS).
- credits = FIFO_DEPTH - FIFO occupancy - results outstanding in the chain.
REQ-017 In IDLE, a handshake (in_valid && in_ready) SHALL send the element with index 0, reserve NUM_CELLS credits, and move the state to STREAM.
REQ-018 In STREAM, in_ready SHALL be 1.
- Each handshake sends the next index.
- The handshake carrying index WEIGHT_AMOUNT-1 returns the state to IDLE.
REQ-019 The chain SHALL be driven one cycle after the handshake, from registers:
- chain_value = in_value; chain_index = the element's index; chain_enable = 1.
- In cycles without a handshake, chain_enable, chain_value and chain_index SHALL be 0.
- The index counter holds its value across gaps.
REQ-020 chain_result SHALL be constantly 0.
REQ-021 Every cycle in which chain_out_result[RESULT_WIDTH]=1 outside FLUSH SHALL push chain_out_result[RESULT_WIDTH-1:0] into the FIFO, in arrival order, and decrement the outstanding count.
REQ-022 res_valid SHALL equal FIFO non-empty, and res_data SHALL be the FIFO head.
- res_valid && res_ready pops one entry and returns one credit.
REQ-023 A simultaneous push and pop SHALL leave the occupancy unchanged, including when the FIFO is full.
- With an empty FIFO, the pushed word appears on res_data the following cycle (no bypass).
REQ-024 A push while the FIFO is full with no pop SHALL drop the word and set overflow until reset.

Reset
REQ-025 On reset, the following SHALL hold:
- state=FLUSH and flush counter loaded.
- in_ready=0, chain_enable=0, chain_value=0, chain_index=0, chain_result=0.
- FIFO emptied, res_valid=0, res_data=0.
- credits=FIFO_DEPTH, outstanding=0, overflow=0, busy=1.
REQ-026 A reset asserted mid-vector SHALL abandon the partial vector.
- Chain results still in flight are discarded by FLUSH.

Configuration
REQ-027 Macro WEIGHT_SEQ_STATS_EN, when defined, SHALL add these outputs, cleared by reset:
- stat_vectors  out  32  increments when the NUM_CELLS-th result of a vector is pushed.
- stat_stalls  out  32  increments in each cycle with in_valid && !in_ready.
REQ-028 When WEIGHT_SEQ_STATS_EN is undefined, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification (WEIGHT_AMOUNT=4, NUM_CELLS=4, FIFO_DEPTH=8)
REQ-029 Reset for 1 cycle, then in_valid held at 1 -> in_ready=0 for 12 cycles, and the first handshake occurs in cycle 13.
REQ-030 Elements 1,2,3,4 sent back-to-back -> chain_index 0,1,2,3 with chain_enable=1 on 4 consecutive cycles, each lagging its handshake by 1 cycle.
- A chain model with weights all 1 returns four flagged results of 10, which appear on res_data in order.
REQ-031 in_valid dropped for 2 cycles after index 1 -> chain_enable=0 for 2 cycles, then index 2 resumes; the results still equal 10.
REQ-032 res_ready=0 with 3 vectors offered:
- The first 2 vectors are admitted, then in_ready=0 (credits 0).
- Once 4 entries are popped, the third vector is admitted.
- overflow stays 0.
REQ-033 FIFO holds 8 entries, then a flagged word arrives in the same cycle as a pop -> occupancy stays 8, with the new word at the tail.
REQ-034 A flagged word forced onto chain_out_result with the FIFO full and res_ready=0 -> overflow=1, occupancy stays 8, and overflow is cleared only by reset.

Source files
------------

// File: rtl/weight_chain_sequencer.sv
// Weight chain sequencer: feeds input vectors element by element into a
// systolic weight chain, collects the flagged per-cell results into a result
// FIFO and throttles new vectors with a credit scheme so that every result
// already admitted into the chain is guaranteed a FIFO slot.
//
// Optional feature: define WEIGHT_SEQ_STATS_EN to add the stat_vectors and
// stat_stalls counter outputs. Without the macro the block is complete and
// those ports are absent.
module weight_chain_sequencer #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned RESULT_WIDTH  = 16,
  parameter int unsigned INDEX_WIDTH   = 10,
  parameter int unsigned WEIGHT_AMOUNT = 4,
  parameter int unsigned NUM_CELLS     = 4,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  // Vector element input
  input  logic [DATA_WIDTH-1:0]   in_value,
  input  logic                    in_valid,
  output logic                    in_ready,
  // Drive side of the first chain cell
  output logic [DATA_WIDTH-1:0]   chain_value,
  output logic [INDEX_WIDTH-1:0]  chain_index,
  output logic                    chain_enable,
  output logic [RESULT_WIDTH:0]   chain_result,
  // Result output of the last chain cell (MSB is the valid flag)
  input  logic [RESULT_WIDTH:0]   chain_out_result,
  // Result stream
  output logic [RESULT_WIDTH-1:0] res_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  // Status
  output logic                    busy,
  output logic                    overflow
`ifdef WEIGHT_SEQ_STATS_EN
  ,
  output logic [31:0]             stat_vectors,
  output logic [31:0]             stat_stalls
`endif
);

  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W     = CNT_W + 2;
  localparam int unsigned IDX_W     = $clog2(WEIGHT_AMOUNT);
  localparam int unsigned FLUSH_LEN = 2 * NUM_CELLS + WEIGHT_AMOUNT;
  localparam int unsigned FLUSH_W   = $clog2(FLUSH_LEN);

  localparam logic [1:0] S_FLUSH  = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  // State and sequencing registers
  logic [1:0]              r_state;
  logic [FLUSH_W-1:0]      r_flush_cnt;
  logic [IDX_W-1:0]        r_idx;

  // Chain drive registers
  logic                    r_chain_en;
  logic [DATA_WIDTH-1:0]   r_chain_val;
  logic [INDEX_WIDTH-1:0]  r_chain_idx;

  // Credit bookkeeping and result FIFO
  logic [CNT_W-1:0]        r_outstanding;
  logic [RESULT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_rptr;
  logic [CNT_W-1:0]        r_count;
  logic                    r_overflow;

  logic                    w_in_ready;
  logic                    w_credit_ok;
  logic [SUM_W-1:0]        w_demand;
  logic                    w_hs;
  logic                    w_reserve;
  logic [IDX_W-1:0]        w_send_idx;
  logic                    w_last;
  logic                    w_arrive;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;
  logic [CNT_W-1:0]        w_out_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A new vector needs one FIFO slot per cell, counting both queued results
  // and results still travelling through the chain.
  assign w_demand    = SUM_W'(r_count) + SUM_W'(r_outstanding) + SUM_W'(NUM_CELLS);
  assign w_credit_ok = (w_demand <= SUM_W'(FIFO_DEPTH));

  // Input ready depends only on state and credits, never on in_valid
  always_comb begin
    w_in_ready = 1'b0;
    unique case (r_state)
      S_IDLE:   w_in_ready = w_credit_ok;
      S_STREAM: w_in_ready = 1'b1;
      default:  w_in_ready = 1'b0;
    endcase
  end

  assign w_hs       = in_valid && w_in_ready;
  assign w_reserve  = w_hs && (r_state == S_IDLE);
  assign w_send_idx = (r_state == S_IDLE) ? '0 : r_idx;
  assign w_last     = (w_send_idx == IDX_W'(WEIGHT_AMOUNT - 1));

  // Results arriving while flushing belong to an abandoned vector
  assign w_arrive = chain_out_result[RESULT_WIDTH] && (r_state != S_FLUSH);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop    = !w_empty && res_ready;
  assign w_push   = w_arrive && (!w_full || w_pop);
  assign w_drop   = w_arrive && w_full && !w_pop;

  // FSM: flush countdown, then alternate between idle and streaming a vector
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FLUSH;
      r_flush_cnt <= FLUSH_W'(FLUSH_LEN - 1);
      r_idx       <= '0;
    end else begin
      unique case (r_state)
        S_FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - FLUSH_W'(1);
          end
        end
        S_IDLE: begin
          if (w_hs) begin
            r_state <= S_STREAM;
            r_idx   <= IDX_W'(1);
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            if (w_last) begin
              r_state <= S_IDLE;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state     <= S_FLUSH;
          r_flush_cnt <= FLUSH_W'(FLUSH_LEN - 1);
          r_idx       <= '0;
        end
      endcase
    end
  end

  // Chain drive: one registered beat per handshake, zeros otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain_en  <= 1'b0;
      r_chain_val <= '0;
      r_chain_idx <= '0;
    end else begin
      r_chain_en  <= w_hs;
      r_chain_val <= w_hs ? in_value : '0;
      r_chain_idx <= w_hs ? INDEX_WIDTH'(w_send_idx) : '0;
    end
  end

  // Outstanding count: reserve a whole vector at its first element, retire
  // one per arriving result. Saturates at zero so a stray flagged word cannot
  // wrap the count.
  always_comb begin
    w_out_next = r_outstanding;
    if (w_reserve) begin
      w_out_next = w_out_next + CNT_W'(NUM_CELLS);
    end
    if (w_arrive && (r_outstanding != '0)) begin
      w_out_next = w_out_next - CNT_W'(1);
    end
  end

  // Outstanding result register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_out_next;
    end
  end

  // FIFO storage; contents need no reset since reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wptr] <= chain_out_result[RESULT_WIDTH-1:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      // Push into a full FIFO is only taken alongside a pop, so the slot the
      // head vacates is the one being written.
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign chain_value  = r_chain_val;
  assign chain_index  = r_chain_idx;
  assign chain_enable = r_chain_en;
  assign chain_result = '0;
  assign res_valid    = !w_empty;
  assign res_data     = w_empty ? '0 : r_mem[r_rptr];
  assign busy         = (r_state != S_IDLE) || (r_outstanding != '0);
  assign overflow     = r_overflow;

`ifdef WEIGHT_SEQ_STATS_EN
  localparam int unsigned RC_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

  logic [RC_W-1:0] r_res_cnt;
  logic [31:0]     r_stat_vectors;
  logic [31:0]     r_stat_stalls;

  // Statistics: a vector is complete when its last cell result arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_cnt      <= '0;
      r_stat_vectors <= '0;
      r_stat_stalls  <= '0;
    end else begin
      if (w_arrive) begin
        if (r_res_cnt == RC_W'(NUM_CELLS - 1)) begin
          r_res_cnt      <= '0;
          r_stat_vectors <= r_stat_vectors + 32'd1;
        end else begin
          r_res_cnt <= r_res_cnt + RC_W'(1);
        end
      end
      if (in_valid && !w_in_ready) begin
        r_stat_stalls <= r_stat_stalls + 32'd1;
      end
    end
  end

  assign stat_vectors = r_stat_vectors;
  assign stat_stalls  = r_stat_stalls;
`endif

endmodule

// File: tb/tb_weight_chain_sequencer.sv
// Self-checking bench for weight_chain_sequencer (default build, no stats).
// A behavioural weight chain answers the DUT; a transaction-level model of
// credits, FIFO contents and vector progress predicts every visible output.
module tb_weight_chain_sequencer;
  localparam int DW = 8;
  localparam int RW = 16;
  localparam int IW = 10;
  localparam int WA = 4;
  localparam int NC = 4;
  localparam int FD = 8;
  localparam int FLUSH_LEN = 2 * NC + WA;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_value;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] chain_value;
  logic [IW-1:0] chain_index;
  logic          chain_enable;
  logic [RW:0]   chain_result;
  logic [RW:0]   chain_out_result;
  logic [RW-1:0] res_data;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic          overflow;

  always #5 clk = ~clk;

  weight_chain_sequencer #(
    .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .INDEX_WIDTH(IW),
    .WEIGHT_AMOUNT(WA), .NUM_CELLS(NC), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset),
    .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready),
    .chain_value(chain_value), .chain_index(chain_index),
    .chain_enable(chain_enable), .chain_result(chain_result),
    .chain_out_result(chain_out_result),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .overflow(overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_flush;
  int          m_phase;
  int          m_out;
  bit          m_ovf;
  int unsigned m_fifo[$];
  int unsigned popped[$];
  int unsigned exp_res[$];
  int unsigned cur_vals[WA];
  bit          e_en;
  int unsigned e_val;
  int unsigned e_idx;
  int          hs_count = 0;
  int          cyc = 0;
  bit          forced = 1'b0;

  // Behavioural chain
  int          weights[NC][WA];
  int unsigned acc[NC];
  typedef struct {
    int unsigned data;
    int          due;
  } sched_t;
  sched_t sched[$];

  typedef struct {
    int unsigned v[WA];
    int          gap_after;
    int          gap_len;
    int unsigned exp[NC];
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_flush = FLUSH_LEN;
    m_phase = 0;
    m_out   = 0;
    m_ovf   = 1'b0;
    m_fifo.delete();
    exp_res.delete();
    e_en  = 1'b0;
    e_val = 0;
    e_idx = 0;
    for (int c = 0; c < NC; c++) acc[c] = 0;
  endtask

  // One clock: check outputs against the model, advance the model, clock,
  // then let the behavioural chain drive its next result word.
  task automatic cycle();
    bit          in_fl, exp_ready, hs, pop, arr, full0;
    int unsigned word, sum;
    if (!reset) begin
      in_fl     = (m_flush > 0);
      exp_ready = !in_fl && (m_phase != 0 || (FD - m_fifo.size() - m_out) >= NC);
      check("in_ready", in_ready, exp_ready);
      check("res_valid", res_valid, m_fifo.size() != 0);
      if (m_fifo.size() != 0) check("res_data", res_data, m_fifo[0]);
      check("busy", busy, in_fl || m_phase != 0 || m_out != 0);
      check("overflow", overflow, m_ovf);
      check("chain_enable", chain_enable, e_en);
      check("chain_value", chain_value, e_val);
      check("chain_index", chain_index, e_idx);
      check("chain_result", chain_result, 0);

      hs    = in_valid && exp_ready;
      pop   = (m_fifo.size() != 0) && res_ready;
      e_en  = hs;
      e_val = hs ? in_value : 0;
      e_idx = hs ? m_phase : 0;
      if (hs) begin
        hs_count++;
        if (m_phase == 0) m_out += NC;
        cur_vals[m_phase] = in_value;
        if (m_phase == WA - 1) begin
          for (int c = 0; c < NC; c++) begin
            sum = 0;
            for (int i = 0; i < WA; i++) sum += weights[c][i] * cur_vals[i];
            exp_res.push_back(sum & 32'hFFFF);
          end
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end

      arr   = chain_out_result[RW] && !in_fl;
      word  = chain_out_result[RW-1:0];
      full0 = (m_fifo.size() == FD);
      if (pop) popped.push_back(m_fifo.pop_front());
      if (arr) begin
        if (m_out > 0) m_out--;
        if (!forced) begin
          check("result_pending", exp_res.size() != 0, 1);
          if (exp_res.size() != 0) check("chain_word", word, exp_res.pop_front());
        end
        if (full0 && !pop) m_ovf = 1'b1;
        else m_fifo.push_back(word);
      end
      if (in_fl) m_flush--;

      if (chain_enable && chain_index < WA) begin
        for (int c = 0; c < NC; c++) acc[c] += weights[c][chain_index] * chain_value;
        if (chain_index == WA - 1) begin
          for (int c = 0; c < NC; c++) begin
            sched.push_back('{acc[c] & 32'hFFFF, cyc + 2 + c});
            acc[c] = 0;
          end
        end
      end
    end
    forced = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) model_reset();
    chain_out_result = '0;
    if (sched.size() != 0 && sched[0].due <= cyc) begin
      chain_out_result = {1'b1, RW'(sched[0].data)};
      void'(sched.pop_front());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic send_vec(input int unsigned vals[WA], input int gap_after, input int gap_len);
    int start, gap_left, k;
    start    = hs_count;
    gap_left = gap_len;
    for (int g = 0; g < 500 && (hs_count - start) < WA; g++) begin
      k = hs_count - start;
      if (k == gap_after + 1 && gap_left > 0) begin
        in_valid = 1'b0;
        gap_left--;
      end else begin
        in_valid = 1'b1;
        in_value = DW'(vals[k]);
      end
      cycle();
    end
    in_valid = 1'b0;
    check("send_done", hs_count - start, WA);
  endtask

  task automatic settle();
    int g;
    for (g = 0; g < 200 && (m_out != 0 || sched.size() != 0); g++) cycle();
    check("settle_bound", g < 200, 1);
  endtask

  task automatic drain();
    int g;
    res_ready = 1'b1;
    for (g = 0; g < 500 && (m_fifo.size() != 0 || m_out != 0 || sched.size() != 0); g++) cycle();
    check("drain_bound", g < 500, 1);
    res_ready = 1'b0;
  endtask

  task automatic set_weights(input int mode);
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < WA; i++)
        weights[c][i] = (mode == 0) ? 1 : (mode == 1) ? (c + i + 1) : int'($urandom_range(1, 7));
  endtask

  initial begin
    int unsigned v[WA];
    int n, start;

    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned v[WA];
    int n, start;

    tbl[0] = '{'{1, 2, 3, 4},         0, 0, '{30, 40, 50, 60}};
    tbl[1] = '{'{255, 255, 255, 255}, 0, 0, '{2550, 3570, 4590, 5610}};
    tbl[2] = '{'{0, 0, 0, 0},         0, 0, '{0, 0, 0, 0}};
    tbl[3] = '{'{7, 0, 9, 1},         0, 3, '{38, 55, 72, 89}};
    tbl[4] = '{'{100, 200, 3, 50},    2, 1, '{709, 1062, 1415, 1768}};

    in_valid = 1'b1;
    in_value = 8'd1;
    res_ready = 1'b0;
    chain_out_result = '0;
    set_weights(0);
    model_reset();

    // Flush timing with in_valid held high
    do_reset();
    check("rst_res_data", res_data, 0);
    check("rst_chain_value", chain_value, 0);
    check("rst_busy", busy, 1);
    n = 0;
    while (!in_ready && n < 50) begin
      cycle();
      n++;
    end
    check("flush_cycles", n, FLUSH_LEN);
    in_valid = 1'b0;

    // Back-to-back vector, unit weights
    popped.delete();
    v = '{1, 2, 3, 4};
    res_ready = 1'b1;
    send_vec(v, 0, 0);
    drain();
    check("b2b_count", popped.size(), NC);
    for (int c = 0; c < NC; c++) if (c < popped.size()) check("b2b_result", popped[c], 10);

    // Two-cycle gap after index 1
    popped.delete();
    send_vec(v, 1, 2);
    drain();
    check("gap_count", popped.size(), NC);
    for (int c = 0; c < NC; c++) if (c < popped.size()) check("gap_result", popped[c], 10);

    // Table of vectors with index- and cell-dependent weights
    set_weights(1);
    for (int t = 0; t < 5; t++) begin
      popped.delete();
      send_vec(tbl[t].v, tbl[t].gap_after, tbl[t].gap_len);
      drain();
      check("tbl_count", popped.size(), NC);
      for (int c = 0; c < NC; c++) if (c < popped.size()) check("tbl_result", popped[c], tbl[t].exp[c]);
    end

    // Credit back-pressure: three vectors offered with res_ready low
    set_weights(0);
    start = hs_count;
    in_valid = 1'b1;
    res_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_value = DW'($urandom);
      cycle();
    end
    check("credit_two_vectors", hs_count - start, 2 * WA);
    check("credit_ready_low", in_ready, 0);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    res_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_value = DW'($urandom);
      cycle();
    end
    check("credit_third_vector", hs_count - start, 3 * WA);
    in_valid = 1'b0;
    check("credit_no_overflow", overflow, 0);
    drain();

    // Full FIFO: push and pop in the same cycle
    v = '{5, 6, 7, 8};
    send_vec(v, 0, 0);
    send_vec(v, 0, 0);
    settle();
    check("full_valid", res_valid, 1);
    popped.delete();
    res_ready = 1'b1;
    forced = 1'b1;
    chain_out_result = {1'b1, 16'hBEEF};
    cycle();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    drain();
    check("pushpop_count", popped.size(), FD + 1);
    if (popped.size() == FD + 1) check("pushpop_tail", popped[FD], 16'hBEEF);

    // Full FIFO, no pop: word dropped, overflow sticky until reset
    send_vec(v, 0, 0);
    send_vec(v, 0, 0);
    settle();
    forced = 1'b1;
    chain_out_result = {1'b1, 16'hCAFE};
    cycle();
    check("ovf_set", overflow, 1);
    popped.delete();
    drain();
    check("ovf_count", popped.size(), FD);
    if (popped.size() == FD) check("ovf_tail_dropped", popped[FD-1] == 16'hCAFE, 0);
    for (int i = 0; i < 5; i++) cycle();
    check("ovf_sticky", overflow, 1);
    do_reset();
    check("ovf_cleared", overflow, 0);
    for (int i = 0; i < FLUSH_LEN; i++) cycle();

    // Reset in the middle of a vector, with results still in the chain
    set_weights(2);
    v = '{9, 8, 7, 6};
    send_vec(v, 0, 0);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_value = DW'(i + 3);
      cycle();
    end
    in_valid = 1'b0;
    do_reset();
    for (int i = 0; i < FLUSH_LEN; i++) cycle();
    check("midrst_fifo_empty", res_valid, 0);
    popped.delete();
    v = '{11, 22, 33, 44};
    send_vec(v, 0, 0);
    drain();
    check("midrst_count", popped.size(), NC);

    // Randomized traffic against the model
    set_weights(2);
    start = hs_count;
    for (int i = 0; i < 3000; i++) begin
      if (m_phase == 0 && (hs_count - start) >= 30 * WA) break;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_value  = DW'($urandom);
      res_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_valid = 1'b0;
    check("rand_vectors", (hs_count - start) >= 30 * WA, 1);
    drain();
    check("rand_no_overflow", overflow, 0);
    check("rand_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
